debug_slave_cmd_ctrl: RTL and testbench

DEBUG_SLAVE_CMD_CTRL -- requirements
Module: debug_slave_cmd_ctrl

---
 rtl/debug_slave_pkg.sv | 19 +
 rtl/debug_slave_sr.sv | 48 ++++
 rtl/debug_slave_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_debug_slave_cmd_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_slave_pkg.sv
// Shared types and constants for the JTAG debug slave command controller.
// Bit positions are offsets below the data-register MSB (index = DR_W - OFS).
package debug_slave_pkg;

  localparam int DR_W_DEF  = 38;
  localparam int IR_W_DEF  = 2;
  localparam int CAP_W_DEF = 32;

  localparam int ACT_OFS = 1;
  localparam int OVR_OFS = 1;
  localparam int PND_OFS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_PEND
  } state_t;

endpackage

// File: rtl/debug_slave_sr.sv
// Capture/shift data register with serial output taken from bit 0.
// Capture and shift strobes are expected to be mutually exclusive.
module debug_slave_sr
  import debug_slave_pkg::*;
#(
  parameter int DR_W  = DR_W_DEF,
  parameter int CAP_W = CAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cap,
  input  logic             i_shift,
  input  logic             i_tdi,
  input  logic [CAP_W-1:0] i_cap_word,
  input  logic             i_ovr,
  input  logic             i_pend,
  output logic [DR_W-1:0]  o_sr,
  output logic             o_tdo
);

  if (DR_W < CAP_W + 2) begin : g_bad_width
    $error("debug_slave_sr: DR_W must be >= CAP_W+2");
  end

  logic [DR_W-1:0] r_sr;
  logic [DR_W-1:0] w_cap;

  always_comb begin
    w_cap                 = '0;
    w_cap[CAP_W-1:0]      = i_cap_word;
    w_cap[DR_W - OVR_OFS] = i_ovr;
    w_cap[DR_W - PND_OFS] = i_pend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else if (i_cap) begin
      r_sr <= w_cap;
    end else if (i_shift) begin
      r_sr <= {i_tdi, r_sr[DR_W-1:1]};
    end
  end

  assign o_sr  = r_sr;
  assign o_tdo = r_sr[0];

endmodule

// File: rtl/debug_slave_cmd_ctrl.sv
// Debug slave command controller: decodes TAP strobes, issues one-hot
// action pulses and tracks pending/overrun status for the CPU side.
module debug_slave_cmd_ctrl
  import debug_slave_pkg::*;
#(
  parameter int DR_W  = DR_W_DEF,
  parameter int IR_W  = IR_W_DEF,
  parameter int CAP_W = CAP_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IR_W-1:0]              ir_in,
  input  logic                         vs_uir,
  input  logic                         vs_cdr,
  input  logic                         vs_sdr,
  input  logic                         vs_udr,
  input  logic                         tdi,
  output logic                         tdo,
  input  logic [(2**IR_W)*CAP_W-1:0]   cap_data,
  input  logic                         act_ack,
  output logic [DR_W-1:0]              jdo,
  output logic [(2**IR_W)-1:0]         take_action,
  output logic [(2**IR_W)-1:0]         take_no_action,
  output logic                         cmd_pending,
  output logic                         cmd_overrun
);

  localparam int NI = 2**IR_W;

  state_t          r_state;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_op;
  logic [DR_W-1:0] r_jdo;
  logic [NI-1:0]   r_ta;
  logic [NI-1:0]   r_tna;
  logic            r_pend;
  logic            r_ovr;

  logic             w_uir, w_cdr, w_sdr, w_udr;
  logic             w_ack, w_busy, w_ovr;
  logic [DR_W-1:0]  w_sr;
  logic [CAP_W-1:0] w_cap_word;
  logic [NI-1:0]    w_onehot;

  // Only the highest-priority strobe of a cycle takes effect.
  assign w_uir = vs_uir;
  assign w_cdr = vs_cdr & ~vs_uir;
  assign w_sdr = vs_sdr & ~vs_uir & ~vs_cdr;
  assign w_udr = vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;

  assign w_ack  = act_ack & (r_state == S_PEND);
  assign w_busy = (r_state == S_ISSUE) |
                  ((r_state == S_PEND) & ~w_ack);
  assign w_ovr  = w_udr & w_busy;

  assign w_cap_word = cap_data[int'(r_ir)*CAP_W +: CAP_W];
  assign w_onehot   = {{(NI-1){1'b0}}, 1'b1} << r_op;

  debug_slave_sr #(
    .DR_W  (DR_W),
    .CAP_W (CAP_W)
  ) u_sr (
    .clk        (clk),
    .reset      (reset),
    .i_cap      (w_cdr),
    .i_shift    (w_sdr),
    .i_tdi      (tdi),
    .i_cap_word (w_cap_word),
    .i_ovr      (r_ovr),
    .i_pend     (r_pend),
    .o_sr       (w_sr),
    .o_tdo      (tdo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_op    <= '0;
      r_jdo   <= '0;
      r_ta    <= '0;
      r_tna   <= '0;
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ta  <= '0;
      r_tna <= '0;
      if (w_uir) r_ir <= ir_in;
      if (w_ovr) begin
        r_ovr <= 1'b1;
      end else if (w_cdr) begin
        r_ovr <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_udr) begin
            r_jdo   <= w_sr;
            r_op    <= r_ir;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_jdo[DR_W - ACT_OFS]) begin
            r_ta    <= w_onehot;
            r_pend  <= 1'b1;
            r_state <= S_PEND;
          end else begin
            r_tna   <= w_onehot;
            r_state <= S_IDLE;
          end
        end
        S_PEND: begin
          if (w_ack) begin
            r_pend <= 1'b0;
            if (w_udr) begin
              r_jdo   <= w_sr;
              r_op    <= r_ir;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign jdo            = r_jdo;
  assign take_action    = r_ta;
  assign take_no_action = r_tna;
  assign cmd_pending    = r_pend;
  assign cmd_overrun    = r_ovr;

endmodule

// File: tb/tb_debug_slave_cmd_ctrl.sv
// Bench for debug_slave_cmd_ctrl: event-time model checked every cycle
// plus directed scenarios with literal expectations.
module tb_debug_slave_cmd_ctrl;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    ir_in = '0;
  logic          vs_uir = 0, vs_cdr = 0, vs_sdr = 0, vs_udr = 0;
  logic          tdi = 0, act_ack = 0;
  logic          tdo;
  logic [127:0]  cap_data;
  logic [37:0]   jdo;
  logic [3:0]    take_action, take_no_action;
  logic          cmd_pending, cmd_overrun;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] UIR  = 4'b1000;
  localparam logic [3:0] CDR  = 4'b0100;
  localparam logic [3:0] SDR  = 4'b0010;
  localparam logic [3:0] UDR  = 4'b0001;

  assign cap_data = {32'hCAFE_F00D, 32'hDEAD_BEEF,
                     32'h1234_5678, 32'hA5A5_0F0F};

  debug_slave_cmd_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .tdi            (tdi),
    .tdo            (tdo),
    .cap_data       (cap_data),
    .act_ack        (act_ack),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_pending    (cmd_pending),
    .cmd_overrun    (cmd_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Model: an accepted update at edge k emits its pulse at edge k+1;
  // the block is busy until that pulse and while an action is pending.
  logic [37:0] m_sr, m_jdo;
  logic [1:0]  m_ir, m_op;
  logic [3:0]  m_ta, m_tna;
  bit          m_act, m_pend, m_ovr, m_p0, m_busy;
  int          m_pcyc = -100;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_sr = '0; m_jdo = '0; m_ir = '0; m_op = '0;
      m_ta = '0; m_tna = '0; m_act = 0; m_pend = 0;
      m_ovr = 0; m_pcyc = -100;
    end else begin
      m_p0 = m_pend;
      m_ta = '0;
      m_tna = '0;
      if (act_ack && m_pend) m_pend = 0;
      m_busy = (m_pcyc == cyc) || m_pend;
      if (m_pcyc == cyc) begin
        if (m_act) begin
          m_ta = 4'b0001 << m_op;
          m_pend = 1;
        end else begin
          m_tna = 4'b0001 << m_op;
        end
      end
      if (vs_uir) begin
        m_ir = ir_in;
      end else if (vs_cdr) begin
        m_sr = '0;
        m_sr[37] = m_ovr;
        m_sr[36] = m_p0;
        m_sr[31:0] = cap_data[int'(m_ir)*32 +: 32];
        m_ovr = 0;
      end else if (vs_sdr) begin
        m_sr = {tdi, m_sr[37:1]};
      end else if (vs_udr) begin
        if (m_busy) begin
          m_ovr = 1;
        end else begin
          m_jdo = m_sr;
          m_op = m_ir;
          m_act = m_sr[37];
          m_pcyc = cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_jdo", 64'(jdo), 64'd0);
      chk("rst_ta", 64'(take_action), 64'd0);
      chk("rst_tna", 64'(take_no_action), 64'd0);
      chk("rst_pend", 64'(cmd_pending), 64'd0);
      chk("rst_ovr", 64'(cmd_overrun), 64'd0);
      chk("rst_tdo", 64'(tdo), 64'd0);
    end else begin
      chk("jdo", 64'(jdo), 64'(m_jdo));
      chk("take_action", 64'(take_action), 64'(m_ta));
      chk("take_no_action", 64'(take_no_action), 64'(m_tna));
      chk("cmd_pending", 64'(cmd_pending), 64'(m_pend));
      chk("cmd_overrun", 64'(cmd_overrun), 64'(m_ovr));
      chk("tdo", 64'(tdo), 64'(m_sr[0]));
      chk("onehot",
          64'($countones(take_action | take_no_action) <= 1), 64'd1);
    end
  end

  task automatic step(input logic [3:0] s, input logic t,
                      input logic a);
    {vs_uir, vs_cdr, vs_sdr, vs_udr} = s;
    tdi = t;
    act_ack = a;
    @(negedge clk);
    #1;
    {vs_uir, vs_cdr, vs_sdr, vs_udr} = NONE;
    tdi = 0;
    act_ack = 0;
  endtask

  task automatic shift_in(input logic [37:0] v);
    for (int i = 0; i < 38; i++) step(SDR, v[i], 0);
  endtask

  task automatic shift_out(output logic [37:0] got);
    for (int i = 0; i < 38; i++) begin
      got[i] = tdo;
      step(SDR, 0, 0);
    end
  endtask

  task automatic load_ir(input logic [1:0] v);
    ir_in = v;
    step(UIR, 0, 0);
  endtask

  logic [37:0] got;

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("lit_rst_jdo", 64'(jdo), 64'd0);
    chk("lit_rst_tdo", 64'(tdo), 64'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("lit_rst_ta", 64'(take_action), 64'd0);
    reset = 1'b0;
    step(NONE, 0, 0);

    // Capture of slice 2 shifted out LSB first.
    load_ir(2);
    step(CDR, 0, 0);
    shift_out(got);
    chk("lit_cap_deadbeef", 64'(got), 64'h00_DEAD_BEEF);

    // Action command on instruction 1.
    shift_in(38'h20_0000_0012);
    load_ir(1);
    step(UDR, 0, 0);
    chk("lit_jdo_act", 64'(jdo), 64'h20_0000_0012);
    chk("lit_ta_early", 64'(take_action), 64'd0);
    step(NONE, 0, 0);
    chk("lit_ta_pulse", 64'(take_action), 64'b0010);
    chk("lit_pend_set", 64'(cmd_pending), 64'd1);
    step(NONE, 0, 0);
    chk("lit_ta_gone", 64'(take_action), 64'd0);

    // Update while pending is dropped and flagged.
    step(UDR, 0, 0);
    chk("lit_ovr_set", 64'(cmd_overrun), 64'd1);
    chk("lit_jdo_keep", 64'(jdo), 64'h20_0000_0012);
    step(NONE, 0, 0);
    chk("lit_no_pulse", 64'(take_action | take_no_action), 64'd0);
    step(CDR, 0, 0);
    chk("lit_ovr_clr", 64'(cmd_overrun), 64'd0);
    shift_out(got);
    chk("lit_cap_status", 64'(got), 64'h30_1234_5678);
    step(NONE, 0, 1);
    chk("lit_pend_clr", 64'(cmd_pending), 64'd0);
    step(NONE, 0, 1);

    // No-action command on instruction 3.
    shift_in(38'h00_0000_00A5);
    load_ir(3);
    step(UDR, 0, 0);
    step(NONE, 0, 0);
    chk("lit_tna_pulse", 64'(take_no_action), 64'b1000);
    chk("lit_tna_nopend", 64'(cmd_pending), 64'd0);
    step(NONE, 0, 0);
    chk("lit_tna_gone", 64'(take_no_action), 64'd0);

    // Ack and update together while pending.
    shift_in(38'h20_0000_0001);
    load_ir(0);
    step(UDR, 0, 0);
    step(NONE, 0, 0);
    chk("lit_ta_ir0", 64'(take_action), 64'b0001);
    shift_in(38'h20_0000_0044);
    load_ir(2);
    step(UDR, 0, 1);
    chk("lit_jdo_ackudr", 64'(jdo), 64'h20_0000_0044);
    step(NONE, 0, 0);
    chk("lit_ta_ackudr", 64'(take_action), 64'b0100);
    chk("lit_ovr_ackudr", 64'(cmd_overrun), 64'd0);
    step(NONE, 0, 1);

    // Reset while the command is in its issue cycle.
    shift_in(38'h20_0000_0005);
    load_ir(1);
    step(UDR, 0, 0);
    reset = 1'b1;
    #1;
    chk("lit_midrst_jdo", 64'(jdo), 64'd0);
    chk("lit_midrst_pend", 64'(cmd_pending), 64'd0);
    step(NONE, 0, 0);
    chk("lit_midrst_ta", 64'(take_action | take_no_action), 64'd0);
    reset = 1'b0;
    shift_in(38'h20_0000_0007);
    load_ir(3);
    step(UDR, 0, 0);
    step(NONE, 0, 0);
    chk("lit_after_rst", 64'(take_action), 64'b1000);
    step(NONE, 0, 1);

    // All strobes at once: only the instruction update applies.
    ir_in = 2;
    step(UIR | CDR | SDR | UDR, 1, 0);
    step(CDR, 0, 0);
    shift_out(got);
    chk("lit_prio", 64'(got), 64'h00_DEAD_BEEF);
    step(NONE, 0, 0);
    step(NONE, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
